// File: rtl/mips_pkg.sv
// mips_pkg: R-type funct codes and multiply/divide FSM states shared by the datapath.
package mips_pkg;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIX} md_state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/operand bundle from control and register file, HI/LO and stall back.
interface mult_div_unit_if;
    logic        op_valid;
    logic [5:0]  funct;
    logic [1:0]  HI_write;
    logic [1:0]  LO_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (output op_valid, funct, HI_write, LO_write, rs_data, rt_data, input hi, lo, busy);
    modport slave  (input op_valid, funct, HI_write, LO_write, rs_data, rt_data, output hi, lo, busy);
endinterface

// File: rtl/mult_div_unit_div_core.sv
// div_core: unsigned radix-2 restoring divider, one quotient bit per step.
module div_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] dsr;
    logic [32:0] sh;
    logic        ge;

    // Partial remainder stays below the divisor, so its shifted form fits in 33 bits.
    assign sh = {remainder, quotient[31]};
    assign ge = sh >= {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (step) begin
            remainder <= ge ? 32'(sh - {1'b0, dsr}) : sh[31:0];
            quotient  <= {quotient[30:0], ge};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO registers with single-cycle multiply and iterative divide.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic        is_mul, is_div, sgn, go_div, step, last;
    logic        neg_q, neg_r, dz;
    logic [31:0] a_mag, b_mag, a_raw, quo, rem, hi_r, lo_r;
    logic [63:0] prod;

    assign is_mul = bus.op_valid && (bus.funct == FUNCT_MULT || bus.funct == FUNCT_MULTU);
    assign is_div = bus.op_valid && (bus.funct == FUNCT_DIV || bus.funct == FUNCT_DIVU);
    assign sgn    = bus.funct == FUNCT_MULT || bus.funct == FUNCT_DIV;
    assign a_mag  = (sgn && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
    assign b_mag  = (sgn && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign prod   = {{32{sgn & bus.rs_data[31]}}, bus.rs_data} * {{32{sgn & bus.rt_data[31]}}, bus.rt_data};
    assign bus.busy = state != MD_IDLE;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    always_comb begin
        go_div    = state == MD_IDLE && is_div;
        step      = state == MD_ITER;
        last      = step && cnt == 5'(DIV_CYCLES - 1);
        state_nxt = go_div ? MD_ITER : last ? MD_FIX : (state == MD_FIX) ? MD_IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            a_raw <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            cnt <= step ? cnt + 5'd1 : 5'd0;
            if (go_div) begin
                neg_q <= sgn && (bus.rs_data[31] ^ bus.rt_data[31]);
                neg_r <= sgn && bus.rs_data[31];
                dz    <= bus.rt_data == '0;
                a_raw <= bus.rs_data;
            end
            if (state == MD_FIX) begin
                hi_r <= dz ? a_raw : neg_r ? -rem : rem;
                lo_r <= dz ? 32'hFFFF_FFFF : neg_q ? -quo : quo;
            end else if (state == MD_IDLE) begin
                if (is_mul) {hi_r, lo_r} <= prod;
                if (bus.HI_write != 2'b00) hi_r <= bus.rs_data;
                if (bus.LO_write != 2'b00) lo_r <= bus.rs_data;
            end
        end
    end

    div_core u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (go_div),
        .step      (step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] mhi, mlo;

    always #5 clk = ~clk;

    mult_div_unit_if bus();
    mult_div_unit #(.DIV_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [63:0] ref_mul(bit s, logic [31:0] a, logic [31:0] b);
        longint p;
        p = s ? longint'($signed(a)) * longint'($signed(b))
              : longint'({32'h0, a}) * longint'({32'h0, b});
        return 64'(p);
    endfunction

    function automatic logic [63:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.funct    = 6'h00;
        bus.HI_write = 2'b00;
        bus.LO_write = 2'b00;
    endtask

    // All issue tasks start and end at a falling edge.
    task automatic do_mul(bit s, logic [31:0] a, logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.funct    = s ? FUNCT_MULT : FUNCT_MULTU;
        bus.rs_data  = a;
        bus.rt_data  = b;
        {mhi, mlo}   = ref_mul(s, a, b);
        @(negedge clk);
        idle_inputs();
        chk("mul_hi", bus.hi, mhi);
        chk("mul_lo", bus.lo, mlo);
        chk("mul_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_mt(logic [1:0] hw, logic [1:0] lw, logic [31:0] a);
        bus.HI_write = hw;
        bus.LO_write = lw;
        bus.rs_data  = a;
        if (hw != 0) mhi = a;
        if (lw != 0) mlo = a;
        @(negedge clk);
        idle_inputs();
        chk("mt_hi", bus.hi, mhi);
        chk("mt_lo", bus.lo, mlo);
    endtask

    task automatic do_div(bit s, logic [31:0] a, logic [31:0] b, bit intrude);
        int cyc;
        bus.op_valid = 1'b1;
        bus.funct    = s ? FUNCT_DIV : FUNCT_DIVU;
        bus.rs_data  = a;
        bus.rt_data  = b;
        @(negedge clk);
        idle_inputs();
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (intrude && cyc == 5) begin
                bus.op_valid = 1'b1;
                bus.funct    = FUNCT_MULT;
                bus.HI_write = 2'b11;
                bus.LO_write = 2'b01;
                bus.rs_data  = 32'h5A5A_1234;
                bus.rt_data  = 32'h0000_0077;
            end else begin
                idle_inputs();
            end
            if (cyc == 16) begin
                chk("mid_hi", bus.hi, mhi);
                chk("mid_lo", bus.lo, mlo);
            end
            @(negedge clk);
        end
        idle_inputs();
        {mhi, mlo} = ref_div(s, a, b);
        chk("div_busy_cycles", 32'(cyc), 32'd33);
        chk("div_hi", bus.hi, mhi);
        chk("div_lo", bus.lo, mlo);
    endtask

    initial begin
        bus.rs_data = '0;
        bus.rt_data = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        mhi = '0;
        mlo = '0;

        do_mul(1'b1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        do_mul(1'b0, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_const", bus.hi, 32'h2);

        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7_lo_const", bus.lo, 32'hFFFF_FFFD);
        do_div(1'b0, 32'd100, 32'd7, 1'b0);
        do_div(1'b0, 32'h1234, 32'd0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

        do_mt(2'b11, 2'b11, 32'hDEAD_BEEF);
        do_mt(2'b01, 2'b00, 32'h0BAD_F00D);
        do_mt(2'b00, 2'b10, 32'h1357_9BDF);

        // MTHI/MTLO and MULT while busy must not disturb the divide result.
        do_div(1'b1, 32'hFFFF_0000, 32'd13, 1'b1);
        do_mul(1'b1, 32'h7FFF_FFFF, 32'h8000_0001);

        // Reset in the middle of a divide aborts it.
        bus.op_valid = 1'b1;
        bus.funct    = FUNCT_DIVU;
        bus.rs_data  = 32'hFFFF;
        bus.rt_data  = 32'd3;
        @(negedge clk);
        idle_inputs();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0;
        mlo = '0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        do_div(1'b0, 32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 24; i++)
            do_mul(1'($urandom_range(0, 1)), $urandom, $urandom);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            do_div(1'($urandom_range(0, 1)), $urandom, b, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++)
            do_mt(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
